// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, and buffers the reply for decode.
// Latency is at least 3 cycles per instruction. Decode backpressure holds the buffer, and no new request is issued while it is held.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [15:0] pc_plus2,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt, req_pc, req_pc_nxt, inst_nxt, inst_pc_nxt;
  logic        squash, squash_nxt, err_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      req_pc  <= 16'h0000;
      inst    <= 16'h0000;
      inst_pc <= 16'h0000;
      squash  <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      req_pc  <= req_pc_nxt;
      inst    <= inst_nxt;
      inst_pc <= inst_pc_nxt;
      squash  <= squash_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    req_pc_nxt  = req_pc;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    squash_nxt  = squash;
    case (state)
      FETCH: begin
        if (imem_rdy) begin
          req_pc_nxt = pc;
          pc_nxt     = pc + 16'd2;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (imem_valid) begin
          if (!squash) begin
            inst_nxt    = imem_data;
            inst_pc_nxt = req_pc;
            state_nxt   = HOLD;
          end else begin
            squash_nxt = 1'b0;
            state_nxt  = FETCH;
          end
        end
      end
      HOLD: begin
        if (inst_ready)
          state_nxt = (inst[15:11] == HALT_OPCODE) ? HALTED : FETCH;
      end
      HALTED: begin
      end
    endcase

    // Redirect overrides everything; an in-flight reply not yet returned is squashed on arrival.
    if (redirect) begin
      pc_nxt      = redirect_pc;
      req_pc_nxt  = req_pc;
      inst_nxt    = inst;
      inst_pc_nxt = inst_pc;
      if (state == WAIT && !imem_valid) begin
        squash_nxt = 1'b1;
        state_nxt  = WAIT;
      end else begin
        squash_nxt = 1'b0;
        state_nxt  = FETCH;
      end
    end
  end

  assign err_nxt    = err | (imem_valid && state != WAIT) | (redirect && redirect_pc[0]);
  assign imem_en    = (state == FETCH);
  assign imem_addr  = pc;
  assign inst_valid = (state == HOLD);
  assign halted     = (state == HALTED);
  assign pc_plus2   = inst_pc + 16'd2;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a variable-latency memory model feeds a scoreboard of expected instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_en, imem_rdy = 1'b0, imem_valid = 1'b0;
  logic [15:0] imem_addr, imem_data = 16'h0000;
  logic [15:0] inst, inst_pc, pc_plus2;
  logic        inst_valid, inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted, err;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdy(imem_rdy),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .inst(inst), .inst_pc(inst_pc), .pc_plus2(pc_plus2),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] d; logic [15:0] a; } exp_t;
  exp_t        sbq[$];
  logic [15:0] mem [logic [15:0]];

  int          checks = 0, errors = 0;
  int          cyc = 0, lat = 1, cnt = 0, ncons = 0, last_cons = 0;
  bit          pend = 0, stale = 0, deliv_prev = 0, rate_chk = 0;
  logic [15:0] maddr = 16'h0000, exp_addr = 16'h0000;
  logic [15:0] hold_inst, hold_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h8000 | {1'b0, a[15:1]};
  endfunction

  // One clock: record what the DUT does at the coming edge, then advance the memory model.
  task automatic tick();
    bit acc, con, rdr, rs;
    logic [15:0] aa, p2;
    exp_t e;
    acc = rst && imem_en && imem_rdy;
    aa  = imem_addr;
    con = rst && inst_valid && inst_ready && !redirect;
    rdr = rst && redirect;
    rs  = !rst;
    if (acc) begin
      chk("req_addr", aa, exp_addr);
      exp_addr = aa + 16'd2;
    end
    if (con) begin
      if (sbq.size() == 0) chk("unexpected_inst", 1, 0);
      else begin
        e  = sbq.pop_front();
        p2 = e.a + 16'd2;
        chk("inst", inst, e.d);
        chk("inst_pc", inst_pc, e.a);
        chk("pc_plus2", pc_plus2, p2);
      end
      if (rate_chk && ncons > 0) chk("rate", cyc - last_cons, 3);
      last_cons = cyc;
      ncons++;
    end
    if (rdr) begin
      sbq.delete();
      deliv_prev = 0;
      if (pend) stale = 1;
      exp_addr = redirect_pc;
    end
    if (rs) begin
      sbq.delete();
      pend = 0; stale = 0; deliv_prev = 0;
      exp_addr = 16'h0000;
    end
    @(posedge clk); #1;
    cyc++;
    imem_valid = 1'b0;
    if (deliv_prev) chk("valid_latency", inst_valid, 1);
    deliv_prev = 0;
    if (acc) begin pend = 1; cnt = lat; maddr = aa; end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend = 0;
        imem_valid = 1'b1;
        imem_data  = rd(maddr);
        if (stale) stale = 0;
        else begin
          sbq.push_back('{rd(maddr), maddr});
          deliv_prev = 1;
        end
      end
    end
  endtask

  initial begin
    mem[16'h0000] = 16'hC001; mem[16'h0002] = 16'hC002;
    mem[16'h0004] = 16'hC003; mem[16'h0006] = 16'hC004;
    mem[16'hFFFE] = 16'hC0FE;

    // Reset
    tick(); tick();
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_inst_pc", inst_pc, 16'h0000);
    chk("rst_imem_en", imem_en, 1);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    rst = 1'b1;

    // Sequential fetch, one instruction every 3 cycles
    imem_rdy = 1'b1; inst_ready = 1'b1; lat = 1; rate_chk = 1;
    for (int i = 0; i < 40 && ncons < 3; i++) tick();
    chk("seq_count", ncons, 3);
    rate_chk = 0;

    // Backpressure on the instruction at 0006
    inst_ready = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk("bp_valid", inst_valid, 1);
    chk("bp_pc", inst_pc, 16'h0006);
    hold_inst = inst; hold_pc = inst_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_inst_stable", inst, hold_inst);
      chk("bp_pc_stable", inst_pc, hold_pc);
      chk("bp_no_req", imem_en, 0);
    end
    lat = 3; inst_ready = 1'b1;
    for (int i = 0; i < 10 && !imem_en; i++) tick();
    chk("bp_next_addr", imem_addr, 16'h0008);

    // Redirect while waiting; stale reply arrives two cycles later
    tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0; lat = 1;
    tick();
    chk("squash_reply_seen", imem_valid, 1);
    chk("squash_no_valid", inst_valid, 0);
    chk("squash_no_en", imem_en, 0);
    tick();
    chk("redir_en", imem_en, 1);
    chk("redir_addr", imem_addr, 16'h0100);
    chk("redir_no_valid", inst_valid, 0);
    chk("redir_err", err, 0);

    // Redirect from HOLD with inst_ready high drops the buffer; then HALT at 0006
    mem[16'h0006] = 16'h0000;
    inst_ready = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk("hold_before_redir", inst_valid, 1);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0006;
    tick();
    redirect = 1'b0;
    chk("redir_drops_inst", inst_valid, 0);
    for (int i = 0; i < 20 && !halted; i++) tick();
    chk("halted", halted, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("halt_no_en", imem_en, 0);
      chk("halt_stays", halted, 1);
    end
    redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    redirect = 1'b0;
    chk("unhalt", halted, 0);
    chk("unhalt_en", imem_en, 1);
    chk("unhalt_addr", imem_addr, 16'h0020);

    // PC wrap from FFFE
    inst_ready = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk("pre_wrap_valid", inst_valid, 1);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    begin
      int n0;
      n0 = ncons;
      for (int i = 0; i < 20 && ncons == n0; i++) tick();
      chk("wrap_consumed", ncons, n0 + 1);
    end
    imem_rdy = 1'b0;
    for (int i = 0; i < 10 && !imem_en; i++) tick();
    chk("wrap_addr", imem_addr, 16'h0000);

    // Stray reply in FETCH sets sticky err
    chk("pre_err", err, 0);
    imem_valid = 1'b1; imem_data = 16'h1234;
    tick();
    chk("err_stray", err, 1);
    tick(); tick(); tick();
    chk("err_sticky", err, 1);
    chk("stray_no_valid", inst_valid, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("err_cleared", err, 0);
    chk("rst_pc", imem_addr, 16'h0000);

    // Odd redirect target: err, yet target still loaded
    redirect = 1'b1; redirect_pc = 16'h0011;
    tick();
    redirect = 1'b0;
    chk("err_odd", err, 1);
    chk("odd_target", imem_addr, 16'h0011);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("final_err", err, 0);
    chk("final_pc", imem_addr, 16'h0000);
    chk("final_en", imem_en, 1);
    chk("final_halted", halted, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
